comp_sar_search: RTL and testbench
==================================

Name: comp_sar_search

Overview:
- Successive-approximation search controller that drives the probe operand of the ALU's magnitude comparator (comp_4_bit class) and consumes its GT/LT/EQ flags.
- Recovers an unknown value presented on the comparator's A input, one bit per clock, MSB first.
- Sits beside the comparator in the Power_ALU datapath. It is the initiator/consumer end of the comparator interface: the comparator answers, this block asks.

Parameters:
- WIDTH, 4, operand width in bits (must match comparator width; legal 2..16)
- CNT_W, $clog2(WIDTH+1), width of the compare-count output

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request a new search; sampled only in IDLE
- a_gt_b  input  1  comparator flag: unknown A > probe
- a_lt_b  input  1  comparator flag: unknown A < probe
- a_eq_b  input  1  comparator flag: unknown A == probe
- probe  output  WIDTH  registered value driven to comparator B input
- busy  output  1  high while in SEARCH
- done  output  1  one-cycle pulse when result/err are valid
- result  output  WIDTH  recovered value; held until next accepted start
- err  output  1  flags were not one-hot during the search; held until next accepted start
- cmp_count  output  CNT_W  number of flag samples used (1..WIDTH); held with result

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, probe=0, busy=0, done=0, result=0, err=0, cmp_count=0, bit index=0.
- Reset has priority over everything and aborts a search mid-operation. No done pulse is produced for the aborted search.
- States: IDLE, SEARCH.
- IDLE:
  - done=0 except in the cycle immediately after completion.
  - On an edge with start=1: probe<=1 at bit WIDTH-1 (others 0), bit index<=WIDTH-1, busy<=1, err<=0, cmp_count<=0, state<=SEARCH.
  - start is accepted even while done=1; back-to-back searches are legal.
- SEARCH:
  - The comparator is combinational, so flags reflect the current probe. Flags are sampled on every edge while in SEARCH.
  - Each sample increments cmp_count.
  - Not exactly one-hot (none or several high): err<=1, result<=0, done<=1, busy<=0, probe<=0, state<=IDLE.
  - a_eq_b: result<=probe, done<=1, busy<=0, probe<=0, state<=IDLE (early exit).
  - a_gt_b, bit index>0: keep the current bit, set bit index-1, bit index<=index-1.
  - a_lt_b, bit index>0: clear the current bit, set bit index-1, bit index<=index-1.
  - bit index=0 with a_gt_b: result<=probe. With a_lt_b: result<=probe with bit 0 cleared. In both cases done<=1, busy<=0, probe<=0, state<=IDLE.
- start is ignored while busy=1.
- Latency:
  - The first probe is visible in the cycle after start is accepted.
  - done rises k cycles after acceptance, where k=cmp_count, 1<=k<=WIDTH.
  - Worst case is WIDTH+1 edges from the start edge to done low again.
- done is high for exactly one cycle. result, err and cmp_count stay stable from that cycle until the next accepted start.
- Arithmetic: probe bits are only set or cleared; no carries or wrap-around occur.

Decomposition:
- Shared package comp_pkg: state encoding (IDLE=1'b0, SEARCH=1'b1) and a DEFAULT_WIDTH=4 constant reused by comp_4_bit benches.
- No internal sub-module; next-probe computation is a local function.
- The comparator is external and instantiated alongside this block; in the bench, comp_4_bit closes the loop.

Test Plan:
- Reset then start, with comp_4_bit A=4'b0000: probes 1000,0100,0010,0001 -> result=0000, cmp_count=4, err=0, done pulse 4 cycles after start.
- A=4'b1111: probes 1000,1100,1110,1111 (EQ) -> result=1111, cmp_count=4.
- A=4'b1000: first probe 1000 gives EQ -> result=1000, cmp_count=1, done 1 cycle after start.
- A=4'b0101, then start asserted in the done cycle with A=4'b1010 -> results 0101 then 1010; probe 1000 appears the cycle after the second start.
- Forced flags 3'b000 on the second sample (bench overrides comparator) -> err=1, result=0000, cmp_count=2, busy falls.
- rst_n=0 during the third probe of a search -> all outputs 0 next cycle, no done pulse. start while busy has no effect on probe sequence.

Source files
------------

// File: rtl/comp_pkg.sv
//------------------------------------------------------------------------------
// comp_pkg : shared state encoding and default width for the comparator slice
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package comp_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

endpackage : comp_pkg

`default_nettype wire

// File: rtl/comp_sar_search.sv
//------------------------------------------------------------------------------
// comp_sar_search : successive-approximation controller that drives the probe
//                   operand of an external magnitude comparator, MSB first.
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module comp_sar_search
    import comp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             a_gt_b,
    input  logic             a_lt_b,
    input  logic             a_eq_b,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [CNT_W-1:0] cmp_count
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] c_PROBE_MSB = {1'b1, {(WIDTH-1){1'b0}}};

    state_t            r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_probe, w_probe_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic [WIDTH-1:0]  r_result, w_result_nxt;
    logic              r_err, w_err_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              w_onehot;

    // Decide the current bit from the comparison, then try the next lower bit.
    function automatic logic [WIDTH-1:0] f_next_probe(
        input logic [WIDTH-1:0] p,
        input logic [IDX_W-1:0] idx,
        input logic             keep
    );
        logic [WIDTH-1:0] v;
        v                     = p;
        v[idx]                = keep;
        v[idx - IDX_W'(1)]    = 1'b1;
        return v;
    endfunction

    assign w_onehot = ({a_gt_b, a_lt_b, a_eq_b} == 3'b100) ||
                      ({a_gt_b, a_lt_b, a_eq_b} == 3'b010) ||
                      ({a_gt_b, a_lt_b, a_eq_b} == 3'b001);

    always_comb begin
        w_state_nxt  = r_state;
        w_probe_nxt  = r_probe;
        w_idx_nxt    = r_idx;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_result_nxt = r_result;
        w_err_nxt    = r_err;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_probe_nxt = c_PROBE_MSB;
                    w_idx_nxt   = IDX_W'(WIDTH - 1);
                    w_busy_nxt  = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SEARCH;
                end
            end
            SEARCH: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (!w_onehot || a_eq_b || (r_idx == '0)) begin
                    if (!w_onehot) begin
                        w_err_nxt    = 1'b1;
                        w_result_nxt = '0;
                    end else if (a_eq_b || a_gt_b) begin
                        w_result_nxt = r_probe;
                    end else begin
                        w_result_nxt = {r_probe[WIDTH-1:1], 1'b0};
                    end
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_probe_nxt = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_probe_nxt = f_next_probe(r_probe, r_idx, a_gt_b);
                    w_idx_nxt   = r_idx - IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_probe  <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_probe  <= w_probe_nxt;
            r_idx    <= w_idx_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_result <= w_result_nxt;
            r_err    <= w_err_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign probe     = r_probe;
    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign err       = r_err;
    assign cmp_count = r_cnt;

endmodule : comp_sar_search

`default_nettype wire

// File: tb/tb_comp_sar_search.sv
//------------------------------------------------------------------------------
// tb_comp_sar_search : directed bench closing the loop through a 4-bit comparator
// Revision           : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_comp_sar_search;
    import comp_pkg::*;

    localparam int WIDTH = DEFAULT_WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             a_gt_b, a_lt_b, a_eq_b;
    logic [WIDTH-1:0] probe;
    logic             busy, done, err;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] cmp_count;

    logic [WIDTH-1:0] a_val;
    logic             force_en;
    logic [2:0]       force_flags;

    int errors = 0;
    int checks = 0;

    // Behavioural 4-bit comparator with an override for fault injection.
    assign a_gt_b = force_en ? force_flags[2] : (a_val >  probe);
    assign a_lt_b = force_en ? force_flags[1] : (a_val <  probe);
    assign a_eq_b = force_en ? force_flags[0] : (a_val == probe);

    comp_sar_search #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_gt_b    (a_gt_b),
        .a_lt_b    (a_lt_b),
        .a_eq_b    (a_eq_b),
        .probe     (probe),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .err       (err),
        .cmp_count (cmp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start a search on A and follow it to the done cycle; probes holds the
    // expected probe sequence as nibbles, MSB nibble first.
    task automatic run_search(input logic [3:0] a, input logic [15:0] probes,
                              input int k, input logic [3:0] exp_res);
        a_val = a;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("first_probe", 16'(probe), 16'h8);
        chk("busy_after_start", 16'(busy), 16'h1);
        chk("err_cleared", 16'(err), 16'h0);
        for (int i = 1; i <= k; i++) begin
            chk("probe_seq", 16'(probe), 16'(probes[15 - 4*(i-1) -: 4]));
            step();
            if (i < k) begin
                chk("done_low_mid", 16'(done), 16'h0);
                chk("busy_mid", 16'(busy), 16'h1);
            end
        end
        chk("done_pulse", 16'(done), 16'h1);
        chk("busy_fall", 16'(busy), 16'h0);
        chk("probe_cleared", 16'(probe), 16'h0);
        chk("result", 16'(result), 16'(exp_res));
        chk("cmp_count", 16'(cmp_count), 16'(k));
        chk("err_ok", 16'(err), 16'h0);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        a_val       = '0;
        force_en    = 1'b0;
        force_flags = 3'b000;
        step();
        step();
        chk("rst_probe", 16'(probe), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_result", 16'(result), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        chk("rst_count", 16'(cmp_count), 16'h0);
        rst_n = 1'b1;
        step();

        run_search(4'b0000, 16'h8421, 4, 4'b0000);
        step();
        chk("done_one_cycle", 16'(done), 16'h0);
        chk("result_held", 16'(result), 16'h0);
        chk("count_held", 16'(cmp_count), 16'h4);

        run_search(4'b1111, 16'h8CEF, 4, 4'b1111);
        step();
        run_search(4'b1000, 16'h8000, 1, 4'b1000);
        step();
        chk("result_held_1000", 16'(result), 16'h8);

        // Back-to-back: second start lands in the done cycle of the first.
        run_search(4'b0101, 16'h8465, 4, 4'b0101);
        run_search(4'b1010, 16'h8CA0, 3, 4'b1010);
        step();
        chk("done_low_b2b", 16'(done), 16'h0);

        // Flags forced to all-zero on the second sample.
        a_val = 4'b0110;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("err_probe1", 16'(probe), 16'h8);
        step();
        chk("err_probe2", 16'(probe), 16'h4);
        force_en    = 1'b1;
        force_flags = 3'b000;
        step();
        force_en = 1'b0;
        chk("err_flag", 16'(err), 16'h1);
        chk("err_done", 16'(done), 16'h1);
        chk("err_busy", 16'(busy), 16'h0);
        chk("err_result", 16'(result), 16'h0);
        chk("err_count", 16'(cmp_count), 16'h2);
        step();
        chk("err_held", 16'(err), 16'h1);
        chk("err_done_low", 16'(done), 16'h0);

        // Start while busy is ignored; reset during the third probe aborts.
        a_val = 4'b1111;
        start = 1'b1;
        step();
        chk("abort_probe1", 16'(probe), 16'h8);
        chk("abort_err_cleared", 16'(err), 16'h0);
        step();
        chk("busy_start_probe2", 16'(probe), 16'hC);
        start = 1'b0;
        step();
        chk("abort_probe3", 16'(probe), 16'hE);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_probe", 16'(probe), 16'h0);
        chk("abort_busy", 16'(busy), 16'h0);
        chk("abort_done", 16'(done), 16'h0);
        chk("abort_result", 16'(result), 16'h0);
        chk("abort_count", 16'(cmp_count), 16'h0);
        step();
        chk("abort_no_done", 16'(done), 16'h0);
        chk("abort_idle_probe", 16'(probe), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_comp_sar_search

`default_nettype wire
